// File: rtl/bias_pwr_seq.sv
// Power sequencer for the shared bias generator: wake-up delay, staggered
// per-consumer enable grants, idle hold-off before power-down, supply-loss trip.
module bias_pwr_seq #(
  parameter int unsigned NREQ        = 2,
  parameter int unsigned WAKE_CYC    = 10,
  parameter int unsigned STAGGER_CYC = 4,
  parameter int unsigned HOLD_CYC    = 16,
  parameter int unsigned CW          = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            avdd_ok,
  output logic            pwdn,
  output logic            bias_rdy,
  output logic [NREQ-1:0] en,
  output logic            fault,
  output logic            busy
);

  typedef enum logic [1:0] {OFF, WAKE, ON, HOLD} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   wake_cnt, wake_n;
  logic [CW-1:0]   stag_cnt, stag_n;
  logic [CW-1:0]   hold_cnt, hold_n;
  logic            pwdn_n, rdy_n, fault_n, busy_n, found;
  logic [NREQ-1:0] en_n, cand, grant;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= OFF;
      wake_cnt <= '0;
      stag_cnt <= '0;
      hold_cnt <= '0;
      pwdn     <= 1'b1;
      bias_rdy <= 1'b0;
      en       <= '0;
      fault    <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      wake_cnt <= wake_n;
      stag_cnt <= stag_n;
      hold_cnt <= hold_n;
      pwdn     <= pwdn_n;
      bias_rdy <= rdy_n;
      en       <= en_n;
      fault    <= fault_n;
      busy     <= busy_n;
    end
  end

  always_comb begin
    state_n = state;
    wake_n  = wake_cnt;
    stag_n  = stag_cnt;
    hold_n  = hold_cnt;
    pwdn_n  = pwdn;
    rdy_n   = bias_rdy;
    en_n    = en;
    fault_n = fault;
    cand    = req & ~en;
    grant   = '0;
    found   = 1'b0;

    // Lowest-index pending request wins the next grant slot.
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!found && cand[i]) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end

    case (state)
      OFF: begin
        pwdn_n = 1'b1;
        rdy_n  = 1'b0;
        en_n   = '0;
        if (req == '0 && avdd_ok) fault_n = 1'b0;
        if (|req && avdd_ok && !fault) begin
          state_n = WAKE;
          pwdn_n  = 1'b0;
          wake_n  = CW'(WAKE_CYC - 1);
        end
      end
      WAKE: begin
        if (req == '0) begin
          state_n = OFF;
          pwdn_n  = 1'b1;
        end else if (wake_cnt == '0) begin
          state_n = ON;
          rdy_n   = 1'b1;
          stag_n  = '0;
        end else begin
          wake_n = wake_cnt - 1'b1;
        end
      end
      ON: begin
        if (req == '0) begin
          state_n = HOLD;
          en_n    = '0;
          hold_n  = CW'(HOLD_CYC - 1);
        end else begin
          // Releases are immediate; a grant to another bit may coincide.
          en_n = en & req;
          if (stag_cnt == '0 && found) begin
            en_n   = (en & req) | grant;
            stag_n = CW'(STAGGER_CYC - 1);
          end else if (stag_cnt != '0) begin
            stag_n = stag_cnt - 1'b1;
          end
        end
      end
      HOLD: begin
        if (|req) begin
          state_n = ON;
          stag_n  = '0;
        end else if (hold_cnt == '0) begin
          state_n = OFF;
          pwdn_n  = 1'b1;
          rdy_n   = 1'b0;
        end else begin
          hold_n = hold_cnt - 1'b1;
        end
      end
      default: state_n = OFF;
    endcase

    if (state != OFF && !avdd_ok) begin
      state_n = OFF;
      pwdn_n  = 1'b1;
      rdy_n   = 1'b0;
      en_n    = '0;
      fault_n = 1'b1;
    end

    busy_n = (state_n != OFF);
  end

endmodule

// File: tb/tb_bias_pwr_seq.sv
// Directed bench for bias_pwr_seq (NREQ=3); per-cycle expected outputs are
// queued with the stimulus and checked one cycle later.
module tb_bias_pwr_seq;

  localparam int unsigned N  = 3;
  localparam int unsigned VW = N + 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req;
  logic         avdd_ok;
  logic         pwdn, bias_rdy, fault, busy;
  logic [N-1:0] en;

  typedef struct {
    string         tag;
    logic [VW-1:0] exp;
  } item_t;

  item_t q[$];
  int    errors = 0;
  int    checks = 0;

  bias_pwr_seq #(
    .NREQ(N),
    .WAKE_CYC(10),
    .STAGGER_CYC(4),
    .HOLD_CYC(16),
    .CW(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .avdd_ok(avdd_ok),
    .pwdn(pwdn),
    .bias_rdy(bias_rdy),
    .en(en),
    .fault(fault),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [VW-1:0] v(input logic p, input logic r,
                                      input logic [N-1:0] e,
                                      input logic f, input logic b);
    return {p, r, e, f, b};
  endfunction

  // Queue the outputs expected after the next rising edge, then compare.
  task automatic step(input string tag, input logic [VW-1:0] exp);
    item_t it;
    logic [VW-1:0] obs;
    q.push_back('{tag, exp});
    @(posedge clk);
    #1;
    while (q.size() > 0) begin
      it  = q.pop_front();
      obs = {pwdn, bias_rdy, en, fault, busy};
      checks++;
      assert (obs === it.exp) else begin
        errors++;
        $error("FAIL %s observed={pwdn,rdy,en,fault,busy}=%b expected=%b",
               it.tag, obs, it.exp);
      end
    end
  endtask

  task automatic steps(input string tag, input int n, input logic [VW-1:0] exp);
    for (int k = 0; k < n; k++) step(tag, exp);
  endtask

  // Caller has raised req in OFF; covers cycles 1..11 of the wake-up.
  task automatic wake_seq(input string tag);
    steps({tag, "_wake"}, 10, v(0, 0, 3'b000, 0, 1));
    step({tag, "_rdy"}, v(0, 1, 3'b000, 0, 1));
  endtask

  initial begin
    rst = 1'b1; req = '0; avdd_ok = 1'b1;
    @(posedge clk); #1;

    // Reset values, and idle behaviour in OFF.
    steps("reset", 2, v(1, 0, 3'b000, 0, 0));
    rst = 1'b0;
    step("idle", v(1, 0, 3'b000, 0, 0));
    avdd_ok = 1'b0;
    step("off_no_supply_no_fault", v(1, 0, 3'b000, 0, 0));
    avdd_ok = 1'b1;

    // Cold start with a single consumer.
    req = 3'b001;
    wake_seq("cold");
    step("cold_en0", v(0, 1, 3'b001, 0, 1));
    steps("cold_steady", 3, v(0, 1, 3'b001, 0, 1));

    // Release to HOLD, full hold-off, then power-down.
    req = 3'b000;
    steps("hold", 16, v(0, 1, 3'b000, 0, 1));
    step("hold_expire", v(1, 0, 3'b000, 0, 0));

    // Staggered grants for three consumers.
    req = 3'b111;
    wake_seq("stag");
    step("stag_en0", v(0, 1, 3'b001, 0, 1));
    steps("stag_gap1", 3, v(0, 1, 3'b001, 0, 1));
    step("stag_en1", v(0, 1, 3'b011, 0, 1));
    steps("stag_gap2", 3, v(0, 1, 3'b011, 0, 1));
    step("stag_en2", v(0, 1, 3'b111, 0, 1));
    steps("stag_all", 2, v(0, 1, 3'b111, 0, 1));

    // Re-request part-way through HOLD: back to ON without a wake delay.
    req = 3'b000;
    steps("hold2", 5, v(0, 1, 3'b000, 0, 1));
    req = 3'b001;
    step("rereq_on", v(0, 1, 3'b000, 0, 1));
    step("rereq_en0", v(0, 1, 3'b001, 0, 1));
    steps("rereq_gap", 3, v(0, 1, 3'b001, 0, 1));

    // Release of bit 0 and grant of bit 1 in the same cycle.
    req = 3'b010;
    step("swap", v(0, 1, 3'b010, 0, 1));
    req = 3'b011;
    steps("swap_gap", 3, v(0, 1, 3'b010, 0, 1));
    step("swap_en01", v(0, 1, 3'b011, 0, 1));

    // Supply loss: trip, no restart while req held, clear on idle.
    avdd_ok = 1'b0;
    step("trip", v(1, 0, 3'b000, 1, 0));
    avdd_ok = 1'b1;
    steps("trip_held", 3, v(1, 0, 3'b000, 1, 0));
    req = 3'b000;
    step("fault_clear", v(1, 0, 3'b000, 0, 0));

    // Wake abort on cycle 4 of WAKE.
    req = 3'b001;
    step("abort_w1", v(0, 0, 3'b000, 0, 1));
    steps("abort_w", 3, v(0, 0, 3'b000, 0, 1));
    req = 3'b000;
    step("abort_off", v(1, 0, 3'b000, 0, 0));
    steps("abort_idle", 3, v(1, 0, 3'b000, 0, 0));

    // Reset mid-operation, then a full restart.
    req = 3'b011;
    wake_seq("mid");
    step("mid_en0", v(0, 1, 3'b001, 0, 1));
    steps("mid_gap", 3, v(0, 1, 3'b001, 0, 1));
    step("mid_en1", v(0, 1, 3'b011, 0, 1));
    rst = 1'b1;
    step("mid_reset", v(1, 0, 3'b000, 0, 0));
    rst = 1'b0;
    wake_seq("restart");
    step("restart_en0", v(0, 1, 3'b001, 0, 1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
